// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter for a single RAM port, with a bounded burst lock.
// Optional RAM_ARB_STATS_EN adds a saturating contention counter (conflict_cnt).
`ifndef DEFAULT_RAM_ADDR_WIDTH
`define DEFAULT_RAM_ADDR_WIDTH 10
`endif

module ram_port_arbiter #(
  parameter int RAM_ADDR_WIDTH = `DEFAULT_RAM_ADDR_WIDTH,
  parameter int MAX_BURST      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  m_rd_en,
  input  logic [1:0]                  m_wr_en,
  input  logic [2*RAM_ADDR_WIDTH-1:0] m_addr,
  input  logic [63:0]                 m_wr_data,
  input  logic [7:0]                  m_wr_strobe,
  output logic [1:0]                  m_busy,
  output logic [1:0]                  m_rd_valid,
  output logic [31:0]                 m_rd_data,
  output logic                        ram_rd_en,
  output logic                        ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_addr,
  output logic [31:0]                 ram_wr_data,
  output logic [3:0]                  ram_wr_strobe,
  input  logic [31:0]                 ram_rd_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]                 conflict_cnt
`endif
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_d;
  logic [CW-1:0] burst_cnt, cnt_d;
  logic          last, last_d;
  logic          rd_tag, rd_vld, rd_fire;
  logic [1:0]    req, gnt;
  logic          sel, below;

  assign req   = m_rd_en | m_wr_en;
  assign below = (burst_cnt < MAX_CNT);

  always_comb begin
    gnt           = 2'b00;
    state_d       = state;
    cnt_d         = burst_cnt;
    last_d        = last;
    sel           = 1'b0;
    rd_fire       = 1'b0;
    ram_rd_en     = 1'b0;
    ram_wr_en     = 1'b0;
    ram_addr      = '0;
    ram_wr_data   = '0;
    ram_wr_strobe = '0;

    // Reset holds off every grant so the RAM sees no access while rst is high
    if (!rst) begin
      case (state)
        IDLE:    gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
        OWN0:    if (req[0] && (below || !req[1])) gnt = 2'b01;
                 else if (req[1])                  gnt = 2'b10;
        OWN1:    if (req[1] && (below || !req[0])) gnt = 2'b10;
                 else if (req[0])                  gnt = 2'b01;
        default: gnt = 2'b00;
      endcase
    end

    sel = gnt[1];
    if (gnt == 2'b00) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      state_d = sel ? OWN1 : OWN0;
      last_d  = sel;
      if (state != state_d)          cnt_d = CW'(1);
      else if (burst_cnt != MAX_CNT) cnt_d = burst_cnt + 1'b1;
    end

    if (gnt != 2'b00) begin
      ram_wr_en     = m_wr_en[sel];
      ram_rd_en     = m_rd_en[sel] & ~m_wr_en[sel];
      rd_fire       = ram_rd_en;
      ram_addr      = sel ? m_addr[AW +: AW]     : m_addr[0 +: AW];
      ram_wr_data   = sel ? m_wr_data[32 +: 32]  : m_wr_data[0 +: 32];
      ram_wr_strobe = sel ? m_wr_strobe[4 +: 4]  : m_wr_strobe[0 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
      rd_vld    <= 1'b0;
      rd_tag    <= 1'b0;
    end else begin
      state     <= state_d;
      burst_cnt <= cnt_d;
      last      <= last_d;
      rd_vld    <= rd_fire;
      if (rd_fire) rd_tag <= sel;
    end
  end

  // Gating with rst drops a read still in flight when reset lands
  assign m_rd_valid = (rd_vld && !rst) ? (rd_tag ? 2'b10 : 2'b01) : 2'b00;
  assign m_rd_data  = ram_rd_data;
  assign m_busy     = req & ~gnt;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      conflict_cnt <= '0;
    else if ((|m_busy) && (conflict_cnt != 16'hFFFF))
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM; a second instance
// uses MAX_BURST=1 to check strict alternation. Stats checks need RAM_ARB_STATS_EN.
module tb_ram_port_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    m_rd_en = '0, m_wr_en = '0;
  logic [2*AW-1:0] m_addr = '0;
  logic [63:0]   m_wr_data = '0;
  logic [7:0]    m_wr_strobe = '0;
  logic [1:0]    m_busy, m_rd_valid;
  logic [31:0]   m_rd_data;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wr_data;
  logic [3:0]    ram_wr_strobe;
  logic [31:0]   ram_rd_data = '0;

  logic [1:0]    alt_busy, alt_rd_valid;
  logic [31:0]   alt_rd_data;
  logic          alt_ram_rd_en, alt_ram_wr_en;
  logic [AW-1:0] alt_ram_addr;
  logic [31:0]   alt_ram_wr_data;
  logic [3:0]    alt_ram_wr_strobe;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   conflict_cnt, alt_conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_port_arbiter #(.RAM_ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_strobe(m_wr_strobe), .m_busy(m_busy),
    .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data), .ram_rd_en(ram_rd_en),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_strobe(ram_wr_strobe), .ram_rd_data(ram_rd_data)
`ifdef RAM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  ram_port_arbiter #(.RAM_ADDR_WIDTH(AW), .MAX_BURST(1)) alt (
    .clk(clk), .rst(rst), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_strobe(m_wr_strobe), .m_busy(alt_busy),
    .m_rd_valid(alt_rd_valid), .m_rd_data(alt_rd_data), .ram_rd_en(alt_ram_rd_en),
    .ram_wr_en(alt_ram_wr_en), .ram_addr(alt_ram_addr), .ram_wr_data(alt_ram_wr_data),
    .ram_wr_strobe(alt_ram_wr_strobe), .ram_rd_data(32'h0)
`ifdef RAM_ARB_STATS_EN
    , .conflict_cnt(alt_conflict_cnt)
`endif
  );

  // Behavioural RAM: byte-strobed write, read data registered one cycle later
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_strobe[b]) mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] s0, input logic [3:0] s1);
    m_rd_en     = rd;
    m_wr_en     = wr;
    m_addr      = {a1, a0};
    m_wr_data   = {d1, d0};
    m_wr_strobe = {s1, s0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

    // Reset: requests are stalled and nothing reaches the RAM
    applyStimulus(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, '0, '0);
    tick();
    checkOutput("rst_busy", {30'b0, m_busy}, 32'h3);
    checkOutput("rst_rd_en", {31'b0, ram_rd_en}, 32'h0);
    checkOutput("rst_wr_en", {31'b0, ram_wr_en}, 32'h0);
    checkOutput("rst_rd_valid", {30'b0, m_rd_valid}, 32'h0);
    idle();
    rst = 1'b0;
    tick();

    // m0 alone: write then read back
    applyStimulus(2'b00, 2'b01, 10'd5, '0, 32'hCAFEF00D, '0, 4'hF, '0);
    checkOutput("t1_wr_busy", {30'b0, m_busy}, 32'h0);
    checkOutput("t1_wr_en", {31'b0, ram_wr_en}, 32'h1);
    checkOutput("t1_wr_addr", {22'b0, ram_addr}, 32'd5);
    checkOutput("t1_wr_data", ram_wr_data, 32'hCAFEF00D);
    tick();
    applyStimulus(2'b01, 2'b00, 10'd5, '0, '0, '0, '0, '0);
    checkOutput("t1_rd_busy", {30'b0, m_busy}, 32'h0);
    checkOutput("t1_rd_en", {31'b0, ram_rd_en}, 32'h1);
    tick();
    idle();
    checkOutput("t1_rd_valid", {30'b0, m_rd_valid}, 32'h1);
    checkOutput("t1_rd_data", m_rd_data, 32'hCAFEF00D);

    // m1 partial-strobe write: only the low two bytes land
    applyStimulus(2'b00, 2'b10, '0, 10'd6, '0, 32'hA5A50001, '0, 4'b0011);
    checkOutput("strb_busy", {30'b0, m_busy}, 32'h0);
    checkOutput("strb_strobe", {28'b0, ram_wr_strobe}, 32'h3);
    tick();

    // Both read straight out of reset: m0 first, then m1
    doReset();
    applyStimulus(2'b11, 2'b00, 10'd5, 10'd6, '0, '0, '0, '0);
    checkOutput("t2_busy_a", {30'b0, m_busy}, 32'h2);
    checkOutput("t2_addr_a", {22'b0, ram_addr}, 32'd5);
    tick();
    applyStimulus(2'b10, 2'b00, 10'd5, 10'd6, '0, '0, '0, '0);
    checkOutput("t2_busy_b", {30'b0, m_busy}, 32'h0);
    checkOutput("t2_addr_b", {22'b0, ram_addr}, 32'd6);
    checkOutput("t2_valid_a", {30'b0, m_rd_valid}, 32'h1);
    checkOutput("t2_data_a", m_rd_data, 32'hCAFEF00D);
    tick();
    idle();
    checkOutput("t2_valid_b", {30'b0, m_rd_valid}, 32'h2);
    checkOutput("t2_data_b", m_rd_data, 32'h00000001);
    tick();

    // Continuous contention: bursts of 4 vs strict alternation with MAX_BURST=1
    applyStimulus(2'b11, 2'b00, 10'd5, 10'd6, '0, '0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("t3_win4_%0d", i), {30'b0, m_busy},
                  ((i / 4) % 2 == 0) ? 32'h2 : 32'h1);
      checkOutput($sformatf("t3_win1_%0d", i), {30'b0, alt_busy},
                  (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    idle();
    tick();

    // Same-cycle write by m0 and read by m1 of the same address
    doReset();
    applyStimulus(2'b10, 2'b01, 10'd9, 10'd9, 32'h12345678, '0, 4'hF, '0);
    checkOutput("t4_busy", {30'b0, m_busy}, 32'h2);
    checkOutput("t4_wr_en", {31'b0, ram_wr_en}, 32'h1);
    tick();
    applyStimulus(2'b10, 2'b00, '0, 10'd9, '0, '0, '0, '0);
    checkOutput("t4_busy_b", {30'b0, m_busy}, 32'h0);
    checkOutput("t4_rd_en", {31'b0, ram_rd_en}, 32'h1);
    tick();
    idle();
    checkOutput("t4_valid", {30'b0, m_rd_valid}, 32'h2);
    checkOutput("t4_data", m_rd_data, 32'h12345678);

    // rd and wr together act as a write with no read valid
    applyStimulus(2'b01, 2'b01, 10'd3, '0, 32'h0BADBEEF, '0, 4'hF, '0);
    checkOutput("rw_rd_en", {31'b0, ram_rd_en}, 32'h0);
    checkOutput("rw_wr_en", {31'b0, ram_wr_en}, 32'h1);
    tick();
    applyStimulus(2'b01, 2'b00, 10'd3, '0, '0, '0, '0, '0);
    checkOutput("rw_valid", {30'b0, m_rd_valid}, 32'h0);
    tick();
    idle();
    checkOutput("rw_data", m_rd_data, 32'h0BADBEEF);
    tick();

    // Reset lands mid m1 burst with a read in flight
    applyStimulus(2'b10, 2'b00, '0, 10'd6, '0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t5_valid_in_rst", {30'b0, m_rd_valid}, 32'h0);
    checkOutput("t5_busy_in_rst", {30'b0, m_busy}, 32'h2);
    checkOutput("t5_rd_en_in_rst", {31'b0, ram_rd_en}, 32'h0);
    tick();
    checkOutput("t5_valid_after", {30'b0, m_rd_valid}, 32'h0);
    checkOutput("t5_rd_en_after", {31'b0, ram_rd_en}, 32'h0);
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 10'd5, 10'd6, '0, '0, '0, '0);
    checkOutput("t5_first_win", {30'b0, m_busy}, 32'h2);
    tick();
    idle();
    tick();

`ifdef RAM_ARB_STATS_EN
    doReset();
    #1;
    checkOutput("st_start", {16'b0, conflict_cnt}, 32'd0);
    applyStimulus(2'b11, 2'b00, 10'd5, 10'd6, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) tick();
    idle();
    checkOutput("st_count", {16'b0, conflict_cnt}, 32'd10);
    rst = 1'b1;
    tick();
    checkOutput("st_clear", {16'b0, conflict_cnt}, 32'd0);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
